// File: rtl/seq_div_16_if.sv
// rtl/seq_div_16_if.sv - request/response bundle for the iterative unsigned divider
//   start        request pulse from the master, sampled only while busy=0
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while a division is in progress
//   done         single-cycle pulse; results valid in the same cycle
//   quotient     unsigned quotient (all ones on divide-by-zero)
//   remainder    unsigned remainder (dividend on divide-by-zero)
//   div_by_zero  set when the captured divisor was 0
interface seq_div_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_16.sv
// rtl/seq_div_16.sv - iterative unsigned restoring divider, one quotient bit per clock
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_div_16_if slave: start/dividend/divisor in, busy/done/quotient/
//          remainder/div_by_zero out
module seq_div_16 #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div_16_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] q_w;       // working quotient, starts as the dividend
  logic [WIDTH-1:0] r_w;       // working remainder
  logic [WIDTH-1:0] d_w;       // captured divisor
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   r_ext;     // {R,Q} shifted left: needs one extra bit of R
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             busy_o;
  logic             done_o;

  assign accept    = bus.start && (state_q != RUN);
  assign last_iter = (state_q == RUN) && (count == LAST);

  // Trial subtract R_shifted - D as R + ~D + 1; the carry out of the top bit
  // means no borrow, i.e. the divisor fits into the shifted remainder.
  always_comb begin
    r_ext     = {r_w, q_w[WIDTH-1]};
    trial     = {1'b0, r_ext} + {1'b0, ~{1'b0, d_w}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
    // Either branch fits in WIDTH bits: on success the difference is below D,
    // on failure r_ext itself is below D.
    r_step    = no_borrow ? trial[WIDTH-1:0] : r_ext[WIDTH-1:0];
    q_step    = {q_w[WIDTH-2:0], no_borrow};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = (bus.divisor == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  // Datapath. The final iteration and the result load share one edge, so the
  // visible outputs take the freshly computed step values on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_w         <= '0;
      r_w         <= '0;
      d_w         <= '0;
      count       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      q_w   <= bus.dividend;
      r_w   <= '0;
      d_w   <= bus.divisor;
      count <= '0;
      if (bus.divisor == '0) begin
        quotient_q  <= '1;
        remainder_q <= bus.dividend;
        dbz_q       <= 1'b1;
      end
    end else if (state_q == RUN) begin
      q_w   <= q_step;
      r_w   <= r_step;
      count <= count + 1'b1;
      if (last_iter) begin
        quotient_q  <= q_step;
        remainder_q <= r_step;
        dbz_q       <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy_o;
  assign bus.done        = done_o;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
